// File: rtl/mux_scan.sv
// Registered N:1 bus multiplexer with a manual (switch-selected) mode and an
// auto-scan mode that steps through the channels with a programmable dwell.
module mux_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 25000000,
  localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          m,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic                      step,
  output logic                      err
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_AUTO   = 2'd2
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_ch;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_m;
  logic               r_valid;
  logic               r_step;
  logic               r_err;

  state_t             w_state_nxt;
  logic [SEL_W-1:0]   w_ch_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_step_nxt;
  logic               w_err_nxt;
  logic               w_sel_ok;
  logic [SEL_W-1:0]   w_ch_wrap;
  logic [WIDTH-1:0]   w_chan [CHANNELS];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    assign w_chan[k] = data_in[k*WIDTH +: WIDTH];
  end

  // Extra MSB keeps the range check meaningful when CHANNELS is a power of two.
  assign w_sel_ok  = ({1'b0, sel} < (SEL_W+1)'(CHANNELS));
  assign w_ch_wrap = (r_ch == CH_LAST) ? {SEL_W{1'b0}} : (r_ch + SEL_W'(1));

  // Next-state decode: mode is sampled every cycle, hold only matters in auto.
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_cnt_nxt   = {CNT_W{1'b0}};
    w_step_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mode) begin
          w_state_nxt = ST_AUTO;
        end else begin
          w_state_nxt = ST_MANUAL;
        end
      end
      ST_MANUAL, ST_AUTO: begin
        if (!mode) begin
          w_state_nxt = ST_MANUAL;
          if (w_sel_ok) begin
            w_ch_nxt = sel;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (r_state == ST_MANUAL) begin
          w_state_nxt = ST_AUTO;
        end else if (hold) begin
          w_cnt_nxt = r_cnt;
        end else if (r_cnt == CNT_LAST) begin
          w_ch_nxt   = w_ch_wrap;
          w_step_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter and output registers; data follows the next channel so m and ch agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ch    <= {SEL_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_m     <= {WIDTH{1'b0}};
      r_valid <= 1'b0;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
      r_err   <= w_err_nxt;
      if ((r_state == ST_MANUAL) || (r_state == ST_AUTO)) begin
        r_m     <= w_chan[w_ch_nxt];
        r_valid <= 1'b1;
      end else begin
        r_m     <= r_m;
        r_valid <= r_valid;
      end
    end
  end

  assign m     = r_m;
  assign ch    = r_ch;
  assign valid = r_valid;
  assign step  = r_step;
  assign err   = r_err;

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: a 4-channel instance for manual/auto/hold/mode
// tests and a 3-channel instance for the out-of-range select case.
module tb_mux_scan;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic [1:0]  sel;
  logic        mode;
  logic        hold;
  logic [7:0]  m;
  logic [1:0]  ch;
  logic        valid, step, err;

  logic [23:0] data3;
  logic [1:0]  sel3;
  logic        mode3;
  logic        hold3;
  logic [7:0]  m3;
  logic [1:0]  ch3;
  logic        valid3, step3, err3;

  int checks   = 0;
  int failures = 0;

  mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) u_dut (
    .clk(clk), .reset(reset), .data_in(data_in), .sel(sel), .mode(mode),
    .hold(hold), .m(m), .ch(ch), .valid(valid), .step(step), .err(err)
  );

  mux_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(3)) u_dut3 (
    .clk(clk), .reset(reset), .data_in(data3), .sel(sel3), .mode(mode3),
    .hold(hold3), .m(m3), .ch(ch3), .valid(valid3), .step(step3), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] dat [4];
    logic [1:0] exp_ch;
    dat[0] = 8'hA0; dat[1] = 8'hB1; dat[2] = 8'hC2; dat[3] = 8'hD3;

    data_in = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    sel = 2'd2; mode = 1'b0; hold = 1'b0; reset = 1'b1;
    data3 = {8'hC2, 8'hB1, 8'hA0};
    sel3 = 2'd1; mode3 = 1'b0; hold3 = 1'b0;

    // Reset held two cycles, then manual start on channel 2
    tick(); tick();
    check("rst_m", 32'(m), 32'h0);
    check("rst_ch", 32'(ch), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_step", 32'(step), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    reset = 1'b0;
    tick();
    check("idle_valid", 32'(valid), 32'h0);
    check("idle_m", 32'(m), 32'h0);
    tick();
    check("man_ch2", 32'(ch), 32'd2);
    check("man_m2", 32'(m), 32'hC2);
    check("man_valid", 32'(valid), 32'h1);

    // Manual select: one clock latency from sel and from data_in
    sel = 2'd1;
    #2;
    check("man_nocomb_ch", 32'(ch), 32'd2);
    tick();
    check("man_ch1", 32'(ch), 32'd1);
    check("man_m1", 32'(m), 32'hB1);
    data_in[15:8] = 8'h55;
    #2;
    check("man_nocomb_m", 32'(m), 32'hB1);
    tick();
    check("man_live", 32'(m), 32'h55);
    check("man_err", 32'(err), 32'h0);
    data_in[15:8] = 8'hB1;

    // Auto scan from reset: each channel held three cycles, wrap 3 -> 0
    reset = 1'b1; mode = 1'b1;
    tick();
    check("arst_ch", 32'(ch), 32'h0);
    check("arst_m", 32'(m), 32'h0);
    check("arst_valid", 32'(valid), 32'h0);
    reset = 1'b0;
    tick();
    check("aidle_ch", 32'(ch), 32'h0);
    check("aidle_valid", 32'(valid), 32'h0);
    for (int i = 1; i <= 13; i++) begin
      tick();
      exp_ch = 2'((i / 3) % 4);
      check("scan_ch", 32'(ch), 32'(exp_ch));
      check("scan_step", 32'(step), 32'((i % 3) == 0));
      check("scan_m", 32'(m), 32'(dat[exp_ch]));
    end

    // Hold on the second cycle of channel 1 for five cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick(); tick(); tick();
    check("hold_pre_ch", 32'(ch), 32'd1);
    tick();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) data_in[15:8] = 8'h77;
      tick();
      check("hold_ch", 32'(ch), 32'd1);
      check("hold_step", 32'(step), 32'h0);
      check("hold_m", 32'(m), (i >= 3) ? 32'h77 : 32'hB1);
    end
    data_in[15:8] = 8'hB1;
    hold = 1'b0;
    tick();
    check("unhold_ch1", 32'(ch), 32'd1);
    check("unhold_step0", 32'(step), 32'h0);
    tick();
    check("unhold_ch2", 32'(ch), 32'd2);
    check("unhold_step1", 32'(step), 32'h1);
    check("unhold_m", 32'(m), 32'hC2);

    // Mode switch mid-dwell on channel 3, then back to auto
    tick(); tick(); tick();
    check("sw_pre_ch3", 32'(ch), 32'd3);
    tick();
    mode = 1'b0; sel = 2'd1;
    tick();
    check("sw_man_ch", 32'(ch), 32'd1);
    check("sw_man_step", 32'(step), 32'h0);
    check("sw_man_m", 32'(m), 32'hB1);
    mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sw_auto_ch1", 32'(ch), 32'd1);
      check("sw_auto_step0", 32'(step), 32'h0);
    end
    tick();
    check("sw_auto_ch2", 32'(ch), 32'd2);
    check("sw_auto_step1", 32'(step), 32'h1);
    reset = 1'b1;
    tick();
    check("mid_rst_ch", 32'(ch), 32'h0);
    check("mid_rst_m", 32'(m), 32'h0);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_step", 32'(step), 32'h0);

    // Three-channel instance: out-of-range select leaves ch and m alone
    sel3 = 2'd2;
    reset = 1'b0;
    tick();
    check("c3_idle_valid", 32'(valid3), 32'h0);
    tick();
    check("c3_ch2", 32'(ch3), 32'd2);
    check("c3_m2", 32'(m3), 32'hC2);
    check("c3_err0", 32'(err3), 32'h0);
    sel3 = 2'd3;
    tick();
    check("c3_oor_err", 32'(err3), 32'h1);
    check("c3_oor_ch", 32'(ch3), 32'd2);
    check("c3_oor_m", 32'(m3), 32'hC2);
    sel3 = 2'd0;
    tick();
    check("c3_sel0_ch", 32'(ch3), 32'd0);
    check("c3_sel0_err", 32'(err3), 32'h0);
    check("c3_sel0_m", 32'(m3), 32'hA0);
    check("c3_step", 32'(step3), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
- Parametrised, registered N:1 bus multiplexer. Successor to the 8-bit 2:1 lab mux.
- Generalised in width and channel count.
- Two modes:
  - manual: channel chosen by switches.
  - auto-scan: cycles through channels with a programmable dwell time and a hold control.
- Drives board displays/LEDs from one of several data sources in later labs.

Parameters:
- WIDTH, 8, bits per channel.
- CHANNELS, 4, number of input channels (legal range 2 to 16).
- DWELL, 25000000, clock cycles per channel in auto mode (must be at least 1).
- Derived localparam SEL_W = max(1, ceil(log2(CHANNELS))); not overridable.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  CHANNELS*WIDTH  packed channel data; channel k = data_in[k*WIDTH +: WIDTH].
- sel  input  SEL_W  manual channel select.
- mode  input  1  0 = manual, 1 = auto-scan.
- hold  input  1  auto mode only: freeze scanning.
- m  output  WIDTH  registered selected data.
- ch  output  SEL_W  currently selected channel index.
- valid  output  1  high once m holds real channel data.
- step  output  1  one-cycle pulse when auto-scan advances ch.
- err  output  1  one-cycle pulse on out-of-range sel in manual mode.

Behaviour:
- Reset:
  - Synchronous and active-high; dominates every other input.
  - Next edge forces m=0, ch=0, valid=0, step=0, err=0, dwell counter=0, state=IDLE.
  - Reset mid-scan or mid-dwell: everything cleared; scan restarts at channel 0 after reset is released.
- States:
  - IDLE: entered only from reset; lasts exactly one cycle with reset low. Moves to MANUAL if mode=0, AUTO if mode=1. valid stays 0; m stays 0.
  - MANUAL:
    - If sel < CHANNELS: ch <= sel.
    - Otherwise ch is unchanged and err pulses for that cycle.
    - hold is ignored.
    - Counter held at 0.
  - AUTO:
    - Counter increments each cycle while hold=0.
    - When counter == DWELL-1: counter <= 0, ch <= ch+1 (wraps CHANNELS-1 -> 0), step=1 for that cycle.
    - DWELL=1: ch advances every cycle and step stays high.
  - hold=1 in AUTO: counter and ch frozen, step=0; m keeps tracking live data of the frozen channel.
- Mode switching (sampled every cycle):
  - MANUAL->AUTO: counter <= 0; scan continues from current ch.
  - AUTO->MANUAL: counter <= 0; ch <= sel (range rule applies); any pending step is suppressed.
- Data path:
  - Each cycle in MANUAL/AUTO: m <= data_in slice of the next ch value, so m and ch always agree on the same cycle.
  - Latency from sel or data_in to m is one clock.
  - valid <= 1 on the first MANUAL/AUTO cycle and stays 1 until reset.
- Non-power-of-two CHANNELS:
  - ch never holds a value >= CHANNELS.
  - Auto wrap compares against CHANNELS-1, not 2^SEL_W-1.
- Output timing: all outputs registered; no combinational path from inputs to outputs.

Test Plan (WIDTH=8, CHANNELS=4, DWELL=3 unless noted; data_in = {8'hD3,8'hC2,8'hB1,8'hA0}):
- Reset held 2 cycles, then released with mode=0, sel=2 -> outputs:
  - While reset is held: m=0, ch=0, valid=0.
  - Cycle after release (IDLE): valid=0.
  - Next cycle: ch=2, m=8'hC2, valid=1.
- Manual select timing: mode=0, sel changes 2->1 on one edge -> ch=1, m=8'hB1 exactly one clock later. Change channel-1 data to 8'h55 -> m=8'h55 one clock later.
- Out-of-range select: CHANNELS=3, sel=3 -> err pulses one cycle, ch and m unchanged. sel=0 -> ch=0, err=0.
- Auto scan wrap: mode=1 from reset ->
  - ch sequence 0,1,2,3,0 with each value held 3 cycles.
  - step high exactly one cycle at each advance.
  - m follows A0, B1, C2, D3, A0.
- Hold: in AUTO, assert hold on the 2nd cycle of ch=1 for 5 cycles -> ch stays 1, no step, m=8'hB1. After release, ch advances to 2 after the 2 remaining dwell cycles.
- Mode switch and reset mid-operation:
  - AUTO at ch=3 mid-dwell, switch mode=0 with sel=1 -> ch=1 next clock, no step.
  - Back to mode=1 -> scan continues 1->2 after a full 3 cycles.
  - Assert reset -> ch=0, m=0, valid=0 next edge.
